// File: rtl/mc_mem_responder.sv
// ============================================================================
// Module      : mc_mem_responder
// Description : Word-organised RAM responder for load/store/fetch requests,
//               with programmable wait states and RISC-V byte/half/word sizing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int c_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int c_CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_CNT_W-1:0]   r_cnt;
   logic                 r_write;
   logic [31:0]          r_addr;
   logic [31:0]          r_wdata;
   logic [2:0]           r_funct3;
   logic [31:0]          r_rdata;
   logic                 r_err;
   logic [31:0]          r_mem [DEPTH_WORDS];

   logic                 w_accept;
   logic                 w_commit;
   logic                 w_cur_write;
   logic [31:0]          w_cur_addr;
   logic [31:0]          w_cur_wdata;
   logic [2:0]           w_cur_funct3;
   logic [c_IDX_W-1:0]   w_idx;
   logic                 w_err;
   logic [31:0]          w_old;
   logic [7:0]           w_byte;
   logic [15:0]          w_half;
   logic [31:0]          w_load;
   logic [31:0]          w_merged;

   assign req_ready  = (r_state == S_IDLE);
   assign resp_valid = (r_state == S_RESP);
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;
   assign w_accept   = (r_state == S_IDLE) && req_valid;
   assign w_commit   = (r_state != S_RESP) && (w_state_nxt == S_RESP);

   // With zero wait states the access commits on the accept edge itself,
   // so the live request is used until the latches hold it.
   assign w_cur_write  = (r_state == S_IDLE) ? req_write  : r_write;
   assign w_cur_addr   = (r_state == S_IDLE) ? req_addr   : r_addr;
   assign w_cur_wdata  = (r_state == S_IDLE) ? req_wdata  : r_wdata;
   assign w_cur_funct3 = (r_state == S_IDLE) ? req_funct3 : r_funct3;
   assign w_idx        = w_cur_addr[c_IDX_W+1:2];

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (req_valid) w_state_nxt = (LATENCY == 0) ? S_RESP : S_WAIT;
         S_WAIT:  if (r_cnt == c_CNT_W'(1)) w_state_nxt = S_RESP;
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_err = 1'b0;
      if ((w_cur_funct3 == 3'b011) || (w_cur_funct3 == 3'b110) || (w_cur_funct3 == 3'b111))
         w_err = 1'b1;
      if (w_cur_write && ((w_cur_funct3 == 3'b100) || (w_cur_funct3 == 3'b101)))
         w_err = 1'b1;
      if ((w_cur_funct3[1:0] == 2'b01) && w_cur_addr[0])
         w_err = 1'b1;
      if ((w_cur_funct3[1:0] == 2'b10) && (w_cur_addr[1:0] != 2'b00))
         w_err = 1'b1;
      if ({2'b00, w_cur_addr[31:2]} >= 32'(DEPTH_WORDS))
         w_err = 1'b1;
   end

   always_comb begin
      w_old  = r_mem[w_idx];
      w_byte = w_old[{w_cur_addr[1:0], 3'b000} +: 8];
      w_half = w_cur_addr[1] ? w_old[31:16] : w_old[15:0];
      w_load = 32'd0;
      case (w_cur_funct3)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b010:  w_load = w_old;
         3'b100:  w_load = {24'd0, w_byte};
         3'b101:  w_load = {16'd0, w_half};
         default: w_load = 32'd0;
      endcase
      w_merged = w_old;
      case (w_cur_funct3[1:0])
         2'b00:   w_merged[{w_cur_addr[1:0], 3'b000} +: 8] = w_cur_wdata[7:0];
         2'b01:   w_merged[{w_cur_addr[1], 4'b0000} +: 16] = w_cur_wdata[15:0];
         2'b10:   w_merged = w_cur_wdata;
         default: w_merged = w_old;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_write  <= 1'b0;
         r_addr   <= 32'd0;
         r_wdata  <= 32'd0;
         r_funct3 <= 3'd0;
         r_rdata  <= 32'd0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_cnt    <= c_CNT_W'(LATENCY);
            r_write  <= req_write;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_funct3 <= req_funct3;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
         end
         if (w_commit) begin
            r_rdata <= (w_err || w_cur_write) ? 32'd0 : w_load;
            r_err   <= w_err;
         end else begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
         end
      end
   end

   // Array is never reset; writes are gated so a store cannot land during reset.
   always_ff @(posedge clk) begin
      if (w_commit && reset_n && w_cur_write && !w_err)
         r_mem[w_idx] <= w_merged;
   end

endmodule

`default_nettype wire
